uart_rx_os16: RTL and testbench

- UART receiver for 8N1 serial frames on `rx`.
- Runs on the shared 16x-oversample `b_tick` from the baud tick generator (one `clk`-wide pulse, 16 per bit period).
- Features: 2-flop input synchroniser, 3-sample majority vote at bit centre, false-start rejection, stop-bit/framing-error detection.
- Drives the byte/strobe pair that the loopback top and downstream command logic consume.

---
 rtl/uart_rx_os16.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_os16.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver driven by a shared 16x oversample tick.
// Three-sample majority vote at bit centre, false-start rejection and framing-error detection.
module uart_rx_os16 #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam logic [TW-1:0] CNT_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] CNT_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] CNT_S2   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic [1:0]           sync_r;
  logic                 rx_s;
  logic [2:0]           state_r, state_s;
  logic [TW-1:0]        tick_r, tick_s, tick_inc_s;
  logic [BW-1:0]        bit_r, bit_s;
  logic [DATA_BITS-1:0] shift_r, shift_s, data_s;
  logic [2:0]           vote_r, vote_s;
  logic                 vote_now_s, at_decide_s, at_last_s;
  logic                 done_s, ferr_s, busy_s;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  assign rx_s = sync_r[1];

  // Two-flop synchroniser, preset high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  // Next-state, tick/bit counting, vote capture and output decisions.
  always_comb begin
    state_s     = state_r;
    bit_s       = bit_r;
    shift_s     = shift_r;
    data_s      = rx_data;
    done_s      = 1'b0;
    ferr_s      = 1'b0;
    tick_inc_s  = (tick_r == CNT_LAST) ? {TW{1'b0}} : (tick_r + TICK_ONE);
    at_decide_s = b_tick & (tick_r == CNT_S2);
    at_last_s   = b_tick & (tick_r == CNT_LAST);
    // The third sample is live on the deciding tick, so the vote includes rx_s directly.
    vote_now_s  = maj3({rx_s, vote_r[1:0]});

    if (b_tick) begin
      tick_s = tick_inc_s;
    end else begin
      tick_s = tick_r;
    end

    if (b_tick && (tick_r == CNT_S0)) begin
      vote_s = {vote_r[2:1], rx_s};
    end else if (b_tick && (tick_r == CNT_S1)) begin
      vote_s = {vote_r[2], rx_s, vote_r[0]};
    end else if (b_tick && (tick_r == CNT_S2)) begin
      vote_s = {rx_s, vote_r[1:0]};
    end else begin
      vote_s = vote_r;
    end

    case (state_r)
      ST_IDLE: begin
        tick_s = {TW{1'b0}};
        if (!rx_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (at_decide_s && vote_now_s) begin
          state_s = ST_IDLE;
        end else if (at_last_s) begin
          state_s = ST_DATA;
          bit_s   = {BW{1'b0}};
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (at_last_s) begin
          shift_s = {maj3(vote_r), shift_r[DATA_BITS-1:1]};
          bit_s   = bit_r + BIT_ONE;
          if (bit_r == BIT_LAST) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        // Decided mid stop bit so a back-to-back start edge is seen from IDLE.
        if (at_decide_s) begin
          if (vote_now_s) begin
            data_s  = shift_r;
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = ST_BREAK;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
        tick_s  = {TW{1'b0}};
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      tick_r    <= {TW{1'b0}};
      bit_r     <= {BW{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      vote_r    <= 3'b000;
      rx_data   <= {DATA_BITS{1'b0}};
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_r   <= state_s;
      tick_r    <= tick_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      vote_r    <= vote_s;
      rx_data   <= data_s;
      rx_done   <= done_s;
      rx_busy   <= busy_s;
      frame_err <= ferr_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: one b_tick every 4 clk, frames driven tick-aligned on rx.
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       rst;
  logic       b_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int checks = 0;
  int failures = 0;

  int   cyc = 0;
  int   done_cnt = 0;
  int   ferr_cnt = 0;
  int   busy_cnt = 0;
  int   both_cnt = 0;
  int   consec_cnt = 0;
  int   done_cyc = 0;
  int   prev_done_cyc = 0;
  logic prev_done = 1'b0;
  logic [7:0] data_log [32];

  int d0, f0, b0;

  uart_rx_os16 #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .b_tick    (b_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Output monitor sampled on the inactive edge.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_done <= rx_done;
    if (rx_done) begin
      data_log[done_cnt[4:0]] <= rx_data;
      done_cnt      <= done_cnt + 1;
      prev_done_cyc <= done_cyc;
      done_cyc      <= cyc;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_busy) busy_cnt <= busy_cnt + 1;
    if (rx_done && frame_err) both_cnt <= both_cnt + 1;
    if (rx_done && prev_done) consec_cnt <= consec_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) @(negedge clk);
      b_tick = 1'b1;
      @(negedge clk);
      b_tick = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int stop_bits);
    rx = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      ticks(16);
    end
    rx = stop;
    ticks(16 * stop_bits);
    rx = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    rx = 1'b1;
    b_tick = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_done", 32'(rx_done), 32'h0);
    check("rst_busy", 32'(rx_busy), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    ticks(4);

    // Clean 0x55
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'h55, 1'b1, 1);
    ticks(2);
    #2;
    check("f55_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("f55_data", 32'(rx_data), 32'h55);
    check("f55_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
    check("f55_busy_idle", 32'(rx_busy), 32'h0);

    // 0x00 with bit 3 forced high for the count-8 sample only
    d0 = done_cnt;
    rx = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        rx = 1'b0; ticks(8);
        rx = 1'b1; ticks(1);
        rx = 1'b0; ticks(7);
      end else begin
        rx = 1'b0; ticks(16);
      end
    end
    rx = 1'b1;
    ticks(18);
    #2;
    check("vote_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("vote_data", 32'(rx_data), 32'h00);

    // Back-to-back 0xA5, 0x3C
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'hA5, 1'b1, 1);
    send_byte(8'h3C, 1'b1, 1);
    ticks(2);
    #2;
    check("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
    check("b2b_first", 32'(data_log[d0[4:0]]), 32'hA5);
    check("b2b_second", 32'(data_log[5'(d0 + 1)]), 32'h3C);
    check("b2b_interval", 32'(done_cyc - prev_done_cyc), 32'd640);
    check("b2b_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);

    // False start: low for 4 ticks
    d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    rx = 1'b0;
    ticks(4);
    rx = 1'b1;
    ticks(16);
    #2;
    check("glitch_busy_cycles", 32'(busy_cnt - b0), 32'd37);
    check("glitch_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("glitch_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_busy_idle", 32'(rx_busy), 32'h0);
    check("glitch_data_kept", 32'(rx_data), 32'h3C);

    // 0xFF with stop held low 20 bit times, then clean 0x12
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'hFF, 1'b0, 20);
    rx = 1'b0;
    #2;
    check("brk_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    check("brk_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("brk_busy_held", 32'(rx_busy), 32'h1);
    check("brk_data_kept", 32'(rx_data), 32'h3C);
    rx = 1'b1;
    ticks(2);
    #2;
    check("brk_busy_released", 32'(rx_busy), 32'h0);
    d0 = done_cnt;
    send_byte(8'h12, 1'b1, 1);
    ticks(2);
    #2;
    check("post_brk_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("post_brk_data", 32'(rx_data), 32'h12);
    check("post_brk_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);

    // Reset mid-DATA of 0xF0 (first four data bits are 0)
    rx = 1'b0;
    ticks(16 + 48);
    repeat (2) @(negedge clk);
    #2;
    check("mid_busy_before_rst", 32'(rx_busy), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_data", 32'(rx_data), 32'h00);
    check("mid_rst_busy", 32'(rx_busy), 32'h0);
    check("mid_rst_done", 32'(rx_done), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ticks(4);
    d0 = done_cnt;
    send_byte(8'hC3, 1'b1, 1);
    ticks(2);
    #2;
    check("c3_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("c3_data", 32'(rx_data), 32'hC3);

    check("never_done_and_ferr", 32'(both_cnt), 32'd0);
    check("never_done_twice", 32'(consec_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
